rf_write_arbiter: RTL and testbench

Write-port arbiter and scheduler for the 32 x 32-bit register file. Two writeback requesters (A: ALU writeback, B: load writeback) compete for the register file's single write port. Accepted writes go into a small FIFO and drain one per cycle onto the port's write enable, address and data. An optional scoreboard reports which registers have writes still pending.

---
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter.sv | 88 ++++++++
 tb/tb_rf_write_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback request and register-file write-port bundle
// Parameters: N (data width), DEPTH (write-FIFO entries, sets fifo_count width)
// master: requesters, stall source and observers. Drives a_*/b_* requests and rf_stall.
// slave:  the arbiter. Drives the readies, the rf_we/rf_rd/rf_wdata write port, fifo_count and busy.
interface rf_write_arbiter_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) ();
  logic                     a_valid;
  logic                     a_ready;
  logic [4:0]               a_rd;
  logic [N-1:0]             a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [4:0]               b_rd;
  logic [N-1:0]             b_data;
  logic                     rf_stall;
  logic                     rf_we;
  logic [4:0]               rf_rd;
  logic [N-1:0]             rf_wdata;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [31:0]              busy;
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, rf_stall,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wdata, fifo_count, busy
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, rf_stall,
    output a_ready, b_ready, rf_we, rf_rd, rf_wdata, fifo_count, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter and write FIFO for the register-file write port
// Ports: clk, rst_n (async active-low), s (rf_write_arbiter_if.slave)
//   s.a_*/s.b_*   : valid/ready writeback requests (rd, data)
//   s.rf_stall    : holds the FIFO drain
//   s.rf_we/rf_rd/rf_wdata : registered register-file write port
//   s.fifo_count  : FIFO occupancy; s.busy : per-register pending-write flags
// Macro RF_SCOREBOARD_EN: builds the busy scoreboard; otherwise busy is tied to zero.
module rf_write_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RR_A, RR_B} rr_t;
  rr_t           rr, rr_d;
  logic [4:0]    rd_mem   [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, a_acc, b_acc, push, pop;
  logic [4:0]    in_rd;
  logic [N-1:0]  in_data;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign a_acc   = s.a_valid && s.a_ready;
  assign b_acc   = s.b_valid && s.b_ready;
  assign in_rd   = a_acc ? s.a_rd : s.b_rd;
  assign in_data = a_acc ? s.a_data : s.b_data;
  // x0 writes finish the handshake but never enter the FIFO
  assign push    = (a_acc || b_acc) && in_rd != 5'd0;
  assign pop     = !empty && !s.rf_stall;
  assign s.fifo_count = count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= RR_A;
    else        rr <= rr_d;
  // the requester not granted wins the next tie
  always_comb rr_d = a_acc ? RR_B : (b_acc ? RR_A : rr);
  // full uses the pre-edge count, so a pop in flight never opens a slot early
  always_comb begin
    s.a_ready = !full && (!s.b_valid || rr == RR_A);
    s.b_ready = !full && (!s.a_valid || rr == RR_B);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s.rf_we    <= 1'b0;
      s.rf_rd    <= '0;
      s.rf_wdata <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + CW'(push) - CW'(pop);
      s.rf_we <= pop;
      if (pop) begin
        s.rf_rd    <= rd_mem[rd_ptr];
        s.rf_wdata <= data_mem[rd_ptr];
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_data;
    end
`ifdef RF_SCOREBOARD_EN
  logic [31:0]   busy;
  logic [AW-1:0] off;
  // an entry is live when its distance from the read pointer is below count
  always_comb begin
    busy = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) busy[rd_mem[i]] = 1'b1;
    end
    if (s.rf_we) busy[s.rf_rd] = 1'b1;
    busy[0] = 1'b0;
  end
  assign s.busy = busy;
`else
  assign s.busy = '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;
  localparam int N = 32;
  localparam int DEPTH = 4;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  wr_t e;
  rf_write_arbiter_if #(.N(N), .DEPTH(DEPTH)) bus ();
  rf_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] bmask(input logic [31:0] m);
    return SB ? m : 32'h0;
  endfunction
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic stall);
    bus.a_valid  = av;
    bus.a_rd     = ard;
    bus.a_data   = ad;
    bus.b_valid  = bv;
    bus.b_rd     = brd;
    bus.b_data   = bd;
    bus.rf_stall = stall;
  endtask
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                     input logic stall, input logic ea, input logic eb);
    drive(av, ard, ad, bv, brd, bd, stall);
    #3;
    chk("a_ready", 32'(bus.a_ready), 32'(ea));
    chk("b_ready", 32'(bus.b_ready), 32'(eb));
    if (ea && av && ard != 5'd0) exp_q.push_back({ard, ad});
    if (eb && bv && brd != 5'd0) exp_q.push_back({brd, bd});
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input logic stall);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, stall);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd %0d data %h, required no write", bus.rf_rd, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 32'(bus.rf_rd), 32'(e.rd));
        chk("wr_data", bus.rf_wdata, e.data);
      end
    end
  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    bus.a_valid = 1'b1;
    #1;
    chk("rst_a_ready", 32'(bus.a_ready), 1);
    chk("rst_b_ready", 32'(bus.b_ready), 0);
    chk("rst_we", 32'(bus.rf_we), 0);
    chk("rst_rd", 32'(bus.rf_rd), 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_busy", bus.busy, 0);
    bus.a_valid = 1'b0;
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // tie after reset goes to A; both x0 so nothing queued
    cyc(1'b1, 5'd0, 32'h111, 1'b1, 5'd0, 32'h222, 1'b0, 1'b1, 1'b0);
    chk("x0_tie_count", 32'(bus.fifo_count), 0);
    // rr now B: lone B x0 write completes, moves rr back to A
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD, 1'b0, 1'b0, 1'b1);
    chk("x0_count", 32'(bus.fifo_count), 0);
    chk("x0_we", 32'(bus.rf_we), 0);
    idle(1, 1'b0);
    chk("x0_we_late", 32'(bus.rf_we), 0);
    // contention: A offers odd rd, B even rd; grants alternate starting with A
    begin
      int ai = 0;
      int bi = 0;
      for (int i = 0; i < 8; i++) begin
        logic [4:0] ard, brd;
        ard = 5'(2 * ai + 1);
        brd = 5'(2 * bi + 2);
        if (i >= 2) chk("contend_we", 32'(bus.rf_we), 1);
        cyc(1'b1, ard, 32'hA000_0000 + 32'(ard), 1'b1, brd, 32'hB000_0000 + 32'(brd),
            1'b0, (i % 2) == 0, (i % 2) == 1);
        if (i % 2 == 0) ai++;
        else bi++;
      end
    end
    idle(3, 1'b0);
    chk("contend_drained", exp_q.size(), 0);
    chk("contend_count", 32'(bus.fifo_count), 0);
    // single write, rr is A again
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("single_count1", 32'(bus.fifo_count), 1);
    chk("single_we1", 32'(bus.rf_we), 0);
    chk("single_busy1", bus.busy, bmask(32'h20));
    idle(1, 1'b0);
    chk("single_we2", 32'(bus.rf_we), 1);
    chk("single_rd2", 32'(bus.rf_rd), 5);
    chk("single_data2", bus.rf_wdata, 32'hDEAD_BEEF);
    chk("single_count2", 32'(bus.fifo_count), 0);
    chk("single_busy2", bus.busy, bmask(32'h20));
    idle(1, 1'b0);
    chk("single_we3", 32'(bus.rf_we), 0);
    chk("single_busy3", bus.busy, 0);
    // full/stall: rr is B, so b_ready stays high while A alone fills the FIFO
    for (int i = 0; i < 4; i++) begin
      chk("stall_we", 32'(bus.rf_we), 0);
      cyc(1'b1, 5'(10 + i), 32'hC0DE_0000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    chk("full_count", 32'(bus.fifo_count), 4);
    chk("full_busy", bus.busy, bmask(32'h3C00));
    cyc(1'b1, 5'd14, 32'hC0DE_0004, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd14, 32'hC0DE_0004, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("full_we", 32'(bus.rf_we), 0);
    // stall released while full: pop happens but the 5th still waits this cycle
    cyc(1'b1, 5'd14, 32'hC0DE_0004, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_we0", 32'(bus.rf_we), 1);
    cyc(1'b1, 5'd14, 32'hC0DE_0004, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("drain_we1", 32'(bus.rf_we), 1);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      chk("drain_we", 32'(bus.rf_we), 1);
    end
    idle(1, 1'b0);
    chk("drain_done_we", 32'(bus.rf_we), 0);
    chk("drain_done_count", 32'(bus.fifo_count), 0);
    chk("drain_done_q", exp_q.size(), 0);
    // reset mid-operation: 3 queued and a write on the port
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'(20 + i), 32'hF00D_0000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 5'd23, 32'hF00D_0003, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_count", 32'(bus.fifo_count), 3);
    chk("pre_rst_we", 32'(bus.rf_we), 1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.rf_we), 0);
    chk("mid_rst_count", 32'(bus.fifo_count), 0);
    chk("mid_rst_busy", bus.busy, 0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    idle(5, 1'b0);
    chk("post_rst_count", 32'(bus.fifo_count), 0);
    chk("post_rst_we", 32'(bus.rf_we), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
